// File: rtl/tlk2711_pkg.sv
// tlk2711_pkg: 8b/10b control codes, fixed frame words and framer state encoding
// shared by the TLK2711 TX test-pattern generator.
package tlk2711_pkg;

    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K28_2 = 8'h5C;
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K30_7 = 8'hFE;
    localparam logic [7:0] D5_6  = 8'hC5;

    localparam logic [15:0] SYNC_WORD = {D5_6, K28_5};
    localparam logic [15:0] SOF_WORD  = {K28_2, K27_7};
    localparam logic [15:0] EOF_WORD  = {K29_7, K30_7};
    localparam logic [15:0] HEAD_0    = 16'hEB90;
    localparam logic [15:0] HEAD_1    = 16'hE116;
    localparam logic [15:0] FILE_END  = 16'h8101;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SOF,
        ST_HEAD0,
        ST_HEAD1,
        ST_FEND,
        ST_LINE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_EOF,
        ST_GAP
    } tx_state_e;

endpackage

// File: rtl/tlk2711_tx_test_gen.sv
// tlk2711_tx_test_gen: continuous test-frame generator for the TLK2711 parallel TX bus.
// The word selected by the current state is registered, so it reaches the pins one cycle later.
module tlk2711_tx_test_gen
    import tlk2711_pkg::*;
#(
    parameter int DATAWIDTH  = 16,
    parameter int SYNC_WORDS = 16,
    parameter int GAP_WORDS  = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_soft_rst,
    input  logic                 i_test_ena,
    input  logic [DATAWIDTH-1:0] i_line_length,
    output logic [DATAWIDTH-1:0] o_2711_txd,
    output logic                 o_2711_tkmsb,
    output logic                 o_2711_tklsb,
    output logic                 o_busy,
    output logic [15:0]          o_frame_cnt
);

    localparam logic [15:0] SYNC_LAST = 16'(SYNC_WORDS - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_WORDS - 1);

    tx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] len_q, len_d;
    logic [14:0] words_q, words_d;
    logic [15:0] csum_q, csum_d;
    logic [15:0] line_q, line_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] txd_q, txd_d;
    logic [1:0]  tk_q, tk_d;
    logic        busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        words_d     = words_q;
        csum_d      = csum_q;
        line_d      = line_q;
        frame_cnt_d = frame_cnt_q;
        txd_d       = SYNC_WORD;
        tk_d        = 2'b01;
        busy_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                state_d = i_test_ena ? ST_SYNC : ST_IDLE;
            end
            ST_SYNC: begin
                cnt_d   = (cnt_q == SYNC_LAST) ? '0 : cnt_q + 16'd1;
                state_d = (cnt_q == SYNC_LAST) ? ST_SOF : ST_SYNC;
            end
            ST_SOF: begin
                txd_d   = SOF_WORD;
                tk_d    = 2'b11;
                busy_d  = 1'b1;
                len_d   = i_line_length;
                // Odd byte counts drop the trailing byte; zero still sends one word.
                words_d = (i_line_length[15:1] == '0) ? 15'd1 : i_line_length[15:1];
                csum_d  = '0;
                state_d = ST_HEAD0;
            end
            ST_HEAD0: begin
                txd_d   = HEAD_0;
                tk_d    = 2'b00;
                busy_d  = 1'b1;
                state_d = ST_HEAD1;
            end
            ST_HEAD1: begin
                txd_d   = HEAD_1;
                tk_d    = 2'b00;
                busy_d  = 1'b1;
                state_d = ST_FEND;
            end
            ST_FEND: begin
                txd_d   = FILE_END;
                tk_d    = 2'b00;
                busy_d  = 1'b1;
                csum_d  = csum_q + FILE_END;
                state_d = ST_LINE;
            end
            ST_LINE: begin
                txd_d   = line_q;
                tk_d    = 2'b00;
                busy_d  = 1'b1;
                csum_d  = csum_q + line_q;
                state_d = ST_LEN;
            end
            ST_LEN: begin
                txd_d   = len_q;
                tk_d    = 2'b00;
                busy_d  = 1'b1;
                csum_d  = csum_q + len_q;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                txd_d   = cnt_q;
                tk_d    = 2'b00;
                busy_d  = 1'b1;
                csum_d  = csum_q + cnt_q;
                cnt_d   = (cnt_q == {1'b0, words_q - 15'd1}) ? '0 : cnt_q + 16'd1;
                state_d = (cnt_q == {1'b0, words_q - 15'd1}) ? ST_CSUM : ST_DATA;
            end
            ST_CSUM: begin
                txd_d   = csum_q;
                tk_d    = 2'b00;
                busy_d  = 1'b1;
                state_d = ST_EOF;
            end
            ST_EOF: begin
                txd_d       = EOF_WORD;
                tk_d        = 2'b11;
                busy_d      = 1'b1;
                line_d      = line_q + 16'd1;
                frame_cnt_d = line_q;
                cnt_d       = '0;
                state_d     = ST_GAP;
            end
            ST_GAP: begin
                cnt_d   = (cnt_q == GAP_LAST) ? '0 : cnt_q + 16'd1;
                state_d = (cnt_q != GAP_LAST) ? ST_GAP : (i_test_ena ? ST_SYNC : ST_IDLE);
            end
            default: state_d = ST_IDLE;
        endcase
        if (i_soft_rst) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            len_d       = '0;
            words_d     = 15'd1;
            csum_d      = '0;
            line_d      = '0;
            frame_cnt_d = '0;
            txd_d       = SYNC_WORD;
            tk_d        = 2'b01;
            busy_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            words_q     <= 15'd1;
            csum_q      <= '0;
            line_q      <= '0;
            frame_cnt_q <= '0;
            txd_q       <= SYNC_WORD;
            tk_q        <= 2'b01;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            words_q     <= words_d;
            csum_q      <= csum_d;
            line_q      <= line_d;
            frame_cnt_q <= frame_cnt_d;
            txd_q       <= txd_d;
            tk_q        <= tk_d;
            busy_q      <= busy_d;
        end
    end

    assign o_2711_txd   = txd_q;
    assign o_2711_tkmsb = tk_q[1];
    assign o_2711_tklsb = tk_q[0];
    assign o_busy       = busy_q;
    assign o_frame_cnt  = frame_cnt_q;

endmodule
